// File: rtl/flash_cache_pkg.sv
// Shared types and constants for the flash ROM line cache.
// The FSM state encoding and line-offset helper live here.
package flash_cache_pkg;

  localparam int FLASH_ADDR_W = 24;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_LO,
    WAIT_HI,
    RESP
  } state_t;

  function automatic int offs_w(input int line_bytes);
    return $clog2(line_bytes);
  endfunction

endpackage

// File: rtl/flash_line_buf.sv
// Byte-wide register array holding one cache line.
// Written one byte at a time during refill, read combinationally by offset.
module flash_line_buf
  import flash_cache_pkg::*;
#(
  parameter  int LINE_BYTES = 8,
  localparam int OFFS_W     = offs_w(LINE_BYTES)
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [OFFS_W-1:0] i_widx,
  input  logic [7:0]        i_wdata,
  input  logic [OFFS_W-1:0] i_ridx,
  output logic [7:0]        o_rdata
);

  logic [7:0] r_mem [LINE_BYTES];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_widx] <= i_wdata;
  end

  assign o_rdata = r_mem[i_ridx];

endmodule

// File: rtl/flash_rom_cache.sv
// Single-line read cache between the NES ROM fetch logic and qspi_flashmem.
// Define FLASH_CACHE_STATS_EN to add saturating hit/miss counters.
module flash_rom_cache
  import flash_cache_pkg::*;
#(
  parameter int LINE_BYTES = 8,
  parameter int ADDR_W     = FLASH_ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_run_nes,
  input  logic              i_invalidate,
  input  logic              i_req_valid,
  input  logic [ADDR_W-1:0] i_req_addr,
  output logic              o_req_ready,
  output logic              o_rsp_valid,
  output logic [7:0]        o_rsp_data,
  input  logic              i_flash_ready,
  output logic              o_flash_read_en,
  output logic [ADDR_W-1:0] o_flash_addr,
`ifdef FLASH_CACHE_STATS_EN
  output logic [15:0]       o_hit_count,
  output logic [15:0]       o_miss_count,
`endif
  input  logic [7:0]        i_flash_rdata
);

  localparam int OFFS_W = offs_w(LINE_BYTES);
  localparam int TAG_W  = ADDR_W - OFFS_W;

  state_t              r_state, w_next_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [TAG_W-1:0]    r_tag;
  logic                r_line_valid;
  logic                r_abort;
  logic [OFFS_W-1:0]   r_fill_idx;
  logic [ADDR_W-1:0]   r_flash_addr;

  logic [TAG_W-1:0]    w_req_tag;
  logic [TAG_W-1:0]    w_cur_tag;
  logic                w_hit;
  logic                w_accept;
  logic                w_last;
  logic                w_fill_we;
  logic [OFFS_W-1:0]   w_fill_next;
  logic [7:0]          w_line_rdata;

  assign w_req_tag   = i_req_addr[ADDR_W-1:OFFS_W];
  assign w_cur_tag   = r_addr[ADDR_W-1:OFFS_W];
  assign w_hit       = r_line_valid && (r_tag == w_req_tag);
  assign w_accept    = (r_state == IDLE) && i_req_valid && i_run_nes && !i_invalidate && !i_reset;
  assign w_last      = (r_fill_idx == OFFS_W'(LINE_BYTES - 1));
  assign w_fill_we   = (r_state == WAIT_HI) && i_flash_ready;
  assign w_fill_next = r_fill_idx + OFFS_W'(1);
  assign o_flash_addr = r_flash_addr;

  flash_line_buf #(.LINE_BYTES(LINE_BYTES)) u_line_buf (
    .i_clk   (i_clk),
    .i_we    (w_fill_we),
    .i_widx  (r_fill_idx),
    .i_wdata (i_flash_rdata),
    .i_ridx  (r_addr[OFFS_W-1:0]),
    .o_rdata (w_line_rdata)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_next_state;
  end

  always_comb begin
    w_next_state    = r_state;
    o_req_ready     = 1'b0;
    o_rsp_valid     = 1'b0;
    o_rsp_data      = 8'h00;
    o_flash_read_en = 1'b0;
    case (r_state)
      IDLE: begin
        o_req_ready = w_accept;
        if (w_accept) w_next_state = w_hit ? RESP : ISSUE;
      end
      ISSUE: begin
        o_flash_read_en = i_flash_ready;
        if (i_flash_ready) w_next_state = WAIT_LO;
      end
      WAIT_LO: if (!i_flash_ready) w_next_state = WAIT_HI;
      WAIT_HI: if (i_flash_ready) w_next_state = w_last ? RESP : ISSUE;
      RESP: begin
        o_rsp_valid  = 1'b1;
        o_rsp_data   = w_line_rdata;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // An invalidate seen at any point of a fill poisons the line it is building.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_addr       <= '0;
      r_tag        <= '0;
      r_line_valid <= 1'b0;
      r_abort      <= 1'b0;
      r_fill_idx   <= '0;
      r_flash_addr <= '0;
    end else begin
      if (w_accept) begin
        r_addr <= i_req_addr;
        if (!w_hit) begin
          r_fill_idx   <= '0;
          r_line_valid <= 1'b0;
          r_abort      <= 1'b0;
          r_flash_addr <= {w_req_tag, {OFFS_W{1'b0}}};
        end
      end
      if (w_fill_we) begin
        if (w_last) begin
          r_line_valid <= !(r_abort || i_invalidate);
          r_tag        <= w_cur_tag;
        end else begin
          r_fill_idx   <= w_fill_next;
          r_flash_addr <= {w_cur_tag, w_fill_next};
        end
      end
      if (i_invalidate) begin
        r_line_valid <= 1'b0;
        if (r_state != IDLE) r_abort <= 1'b1;
      end
    end
  end

`ifdef FLASH_CACHE_STATS_EN
  logic [15:0] r_hit_count;
  logic [15:0] r_miss_count;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else if (w_accept) begin
      if (w_hit) begin
        if (r_hit_count != 16'hFFFF) r_hit_count <= r_hit_count + 16'd1;
      end else begin
        if (r_miss_count != 16'hFFFF) r_miss_count <= r_miss_count + 16'd1;
      end
    end
  end

  assign o_hit_count  = r_hit_count;
  assign o_miss_count = r_miss_count;
`endif

endmodule

// File: doc/flash_rom_cache.md
Name: flash_rom_cache

Overview:
- Single-line read buffer between the NES cartridge ROM fetch logic and qspi_flashmem.
- Serves byte reads from a LINE_BYTES-byte line held in registers.
- On a miss, refills the aligned line byte-by-byte through the flash controller's read_en/addr/ready/rdata handshake.
- Sequential PRG/CHR fetches mostly hit and avoid the QSPI command overhead.

Parameters:
- LINE_BYTES, 8: bytes per line, power of two, 2..32.
- ADDR_W, 24: byte address width, matches the flash controller address.

Ports:
- clk  in  1  system clock, same as qspi_flashmem clk
- reset  in  1  synchronous, active-high
- run_nes  in  1  when low, no new host requests are accepted
- invalidate  in  1  one-cycle pulse; drop line contents (ROM image reload)
- req_valid  in  1  host read request
- req_addr  in  ADDR_W  host byte address
- req_ready  out  1  request accepted this cycle
- rsp_valid  out  1  one-cycle pulse, rsp_data valid
- rsp_data  out  8  returned byte
- flash_ready  in  1  from qspi_flashmem ready
- flash_read_en  out  1  to qspi_flashmem read_en
- flash_addr  out  ADDR_W  to qspi_flashmem addr
- flash_rdata  in  8  from qspi_flashmem rdata

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: req_ready=0, rsp_valid=0, rsp_data=0, flash_read_en=0, flash_addr=0, line_valid=0, state=IDLE.
- Tag and offset: tag = req_addr[ADDR_W-1:log2(LINE_BYTES)]. Offset = low bits.
- IDLE:
  - req_ready = req_valid & run_nes & ~invalidate.
  - On acceptance, latch addr.
  - Hit (line_valid and tag equal) -> RESP.
  - Miss -> ISSUE, fill_idx=0, line_valid=0.
- Hit latency: rsp_valid exactly 1 cycle after req_ready, with data = line[offset].
- ISSUE:
  - Only when flash_ready=1: pulse flash_read_en for one cycle, flash_addr = {tag, fill_idx} -> WAIT_LO.
  - If flash_ready=0, wait in ISSUE.
- WAIT_LO: wait until flash_ready=0 -> WAIT_HI.
- WAIT_HI:
  - When flash_ready=1, write flash_rdata into line[fill_idx].
  - If fill_idx == LINE_BYTES-1 -> set line_valid=1 and tag, then RESP.
  - Otherwise fill_idx++ -> ISSUE.
- RESP:
  - rsp_valid=1, rsp_data=line[offset] -> IDLE.
  - req_ready stays 0 in this cycle, so back-to-back hits run at one request per 2 cycles.
- Miss latency: LINE_BYTES flash transactions plus 2 cycles.
- flash_addr stays stable from ISSUE until the next ISSUE.
- One outstanding request only. req_addr is ignored after acceptance.
- invalidate in IDLE: line_valid cleared next cycle; a simultaneous req_valid is not accepted.
- invalidate during a fill:
  - The current flash transaction completes.
  - The line is marked dirty-abort: line_valid stays 0.
  - The pending response is still delivered from the freshly fetched bytes.
  - The next request always misses.
- run_nes low mid-fill: the fill and response complete. Only new acceptance is blocked.
- reset mid-fill: immediate return to IDLE, outputs at reset values. The flash controller shares the reset, so no transaction is left dangling.
- Address wrap: a line at the top of the address space never crosses 2^ADDR_W, because lines are aligned.

Optional Feature:
- Macro: FLASH_CACHE_STATS_EN.
- With the macro:
  - Adds outputs hit_count[15:0] and miss_count[15:0].
  - Each counts accepted requests, saturating at 16'hFFFF.
  - Both clear on reset. invalidate does not clear them.
- Without the macro: these ports and counters do not exist, and behaviour is otherwise identical.

Decomposition:
- Shared package flash_cache_pkg holds:
  - state enum (IDLE, ISSUE, WAIT_LO, WAIT_HI, RESP)
  - FLASH_ADDR_W=24
  - OFFS_W = $clog2(LINE_BYTES) helper
- Natural sub-module flash_line_buf:
  - LINE_BYTES x 8 register array.
  - Byte write at fill_idx, combinational read at offset.
- The FSM and tag compare stay in the top.

Test Plan:
- Cold miss:
  - Stimulus: req 24'h55AACC with a behavioural flash model returning addr[7:0]^8'h5A.
  - Required: exactly 8 read_en pulses at 24'h55AAC8..55AACF, then rsp_data=8'h96.
- Hit after fill:
  - Stimulus: req 24'h55AACF.
  - Required: rsp_valid 1 cycle after req_ready, data 8'h95, zero read_en pulses.
- Tag change:
  - Stimulus: req 24'h000010.
  - Required: full refill at 000010..000017, data 8'h4A.
- Invalidate mid-fill:
  - Stimulus: pulse invalidate during the 3rd byte of a fill.
  - Required: fill completes, response correct, and the repeat request to the same line refetches 8 bytes.
- Flash busy / run_nes:
  - Stimulus: hold flash_ready=0 for 20 cycles at ISSUE; drop run_nes with req_valid high.
  - Required: no read_en while ready=0; req_ready stays 0 while run_nes=0.
- Reset mid-fill, then stats (with FLASH_CACHE_STATS_EN):
  - Stimulus: assert reset during WAIT_HI.
  - Required: next cycle all outputs at reset values, and the following request misses.
  - With FLASH_CACHE_STATS_EN, after 1 miss + 3 hits: hit_count=3, miss_count=1.
